// File: rtl/serial_mac_pkg.sv
// Shared types and constants for the bit-serial term multiply-accumulate stage.
package serial_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SHIFT_MAX = 10;
  localparam int ACC_W_DEF = 24;

endpackage

// File: rtl/serial_term_mac_term_shifter.sv
// Term arithmetic: gate the activation by mantissa, shift by exp+bsig, negate on sign.
module term_shifter
  import serial_mac_pkg::*;
#(
  parameter int ACT_W = 8,
  parameter int PW    = ACT_W + SHIFT_MAX + 1
) (
  input  logic signed [ACT_W-1:0] act,
  input  logic                    sign,
  input  logic [1:0]              exp,
  input  logic                    mantissa,
  input  logic [2:0]              bsig,
  output logic signed [PW-1:0]    prod
);

  logic signed [PW-1:0] mag;
  logic signed [PW-1:0] shifted;
  logic [3:0]           sh;

  always_comb begin
    mag     = mantissa ? PW'(act) : '0;
    sh      = {2'b00, exp} + {1'b0, bsig};
    shifted = mag <<< sh;
    prod    = sign ? -shifted : shifted;
  end

endmodule

// File: rtl/serial_term_mac.sv
// Bit-serial MAC: S1 registers the term product, S2 accumulates, result on valid/ready.
// Optional macro SERIAL_MAC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module serial_term_mac
  import serial_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int ACT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic signed [ACT_W-1:0] act,
  input  logic                    sign,
  input  logic [1:0]              exp,
  input  logic                    mantissa,
  input  logic [2:0]              bsig,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_ovf
);

  localparam int PW = ACT_W + SHIFT_MAX + 1;
  // Sum width covers both operands plus a carry, so overflow is judged on the full product.
  localparam int EW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  state_t state, state_next;

  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    s1_prod;
  logic                    s1_valid;
  logic                    s1_last;
  logic                    s2_last;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic                    ovf;
  logic signed [EW-1:0]    sum;
  logic                    ovf_now;
  logic                    accept;
  logic                    last_pending;

  term_shifter #(
    .ACT_W (ACT_W),
    .PW    (PW)
  ) u_term_shifter (
    .act      (act),
    .sign     (sign),
    .exp      (exp),
    .mantissa (mantissa),
    .bsig     (bsig),
    .prod     (prod)
  );

  assign last_pending = (s1_valid && s1_last) || s2_last;
  assign in_ready     = !reset && (state != DONE) && !last_pending;
  assign accept       = in_valid && in_ready;

  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign out_ovf   = ovf;

  always_comb begin
    sum     = EW'(acc) + EW'(s1_prod);
    ovf_now = (sum[EW-1:ACC_W-1] != '0) && (sum[EW-1:ACC_W-1] != '1);
`ifdef SERIAL_MAC_SAT_EN
    // Once clamped the accumulator holds its rail until the result is handed off.
    if (ovf) begin
      acc_next = acc;
    end else if (ovf_now) begin
      acc_next = sum[EW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_next = sum[ACC_W-1:0];
    end
`else
    acc_next = sum[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCUM;
      ACCUM:   if (s2_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      s2_last  <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_next;
      s1_valid <= accept;
      s1_last  <= accept && in_last;
      if (accept) s1_prod <= prod;
      s2_last  <= s1_valid && s1_last;
      if (state == DONE && out_ready) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (s1_valid) begin
        acc <= acc_next;
        if (ovf_now) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_term_mac.sv
// Directed self-checking bench for serial_term_mac (24-bit default instance plus a 16-bit overflow instance).
module tb_serial_term_mac;

  logic               clk;
  logic               reset;
  logic               in_valid, in_ready, in_last;
  logic signed [7:0]  act;
  logic               sign, mantissa;
  logic [1:0]         exp;
  logic [2:0]         bsig;
  logic               out_valid, out_ready, out_ovf;
  logic signed [23:0] out_data;

  logic               in_valid16, in_ready16, in_last16;
  logic signed [7:0]  act16;
  logic               sign16, mantissa16;
  logic [1:0]         exp16;
  logic [2:0]         bsig16;
  logic               out_valid16, out_ready16, out_ovf16;
  logic signed [15:0] out_data16;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_term_mac #(.ACC_W(24), .ACT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .act(act), .sign(sign), .exp(exp), .mantissa(mantissa), .bsig(bsig),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  serial_term_mac #(.ACC_W(16), .ACT_W(8)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16), .in_last(in_last16),
    .act(act16), .sign(sign16), .exp(exp16), .mantissa(mantissa16), .bsig(bsig16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16), .out_ovf(out_ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic signed [7:0] a, input logic s, input logic [1:0] e,
                     input logic m, input logic [2:0] b, input logic l);
    in_valid = 1'b1; act = a; sign = s; exp = e; mantissa = m; bsig = b; in_last = l;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0; act = '0; sign = 1'b0; exp = '0; mantissa = 1'b0; bsig = '0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    out_ready = 1'b0;
    in_valid16 = 1'b0; in_last16 = 1'b0; act16 = '0; sign16 = 1'b0; exp16 = '0;
    mantissa16 = 1'b0; bsig16 = '0; out_ready16 = 1'b0;
    tick(); tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 24'sd0) $display("FAIL reset_out_data: got %0d expected 0", out_data); else pass_cnt++;
    total_cnt++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during: got %b expected 0", in_ready); else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_two_terms();
    put(8'sd5, 1'b0, 2'd0, 1'b1, 3'd0, 1'b0);
    tick();
    put(8'sd5, 1'b0, 2'd1, 1'b1, 3'd2, 1'b1);
    tick();
    idle_in();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL two_terms_ready_drop: got %b expected 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL two_terms_early_t0: got %b expected 0", out_valid); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL two_terms_early_t1: got %b expected 0", out_valid); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL two_terms_valid_t2: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 24'sd45) $display("FAIL two_terms_data: got %0d expected 45", out_data); else pass_cnt++;
    total_cnt++; if (out_ovf !== 1'b0) $display("FAIL two_terms_ovf: got %b expected 0", out_ovf); else pass_cnt++;
    handshake();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL two_terms_valid_clear: got %b expected 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_single_neg();
    put(-8'sd3, 1'b1, 2'd1, 1'b1, 3'd6, 1'b1);
    tick();
    idle_in();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL single_ready_t0: got %b expected 0", in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL single_ready_t1: got %b expected 0", in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 24'sd384) $display("FAIL single_data: got %0d expected 384", out_data); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL single_ready_done: got %b expected 0", in_ready); else pass_cnt++;
    handshake();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL single_ready_after_hs: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_data !== 24'sd0) $display("FAIL single_acc_cleared: got %0d expected 0", out_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic             s_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]       e_tab [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
    logic             m_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]       b_tab [4] = '{3'd0, 3'd2, 3'd4, 3'd6};
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        put(8'sd7, s_tab[i], e_tab[i], m_tab[i], b_tab[i], (w == 1 && i == 3));
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_stall w%0d t%0d: got %b expected 1", w, i, in_ready); else pass_cnt++;
        tick();
      end
    end
    idle_in();
    tick(); tick();
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 24'sd406) $display("FAIL b2b_data: got %0d expected 406", out_data); else pass_cnt++;
    handshake();
  endtask

  task automatic test_overflow16();
    logic signed [15:0] exp_data;
`ifdef SERIAL_MAC_SAT_EN
    exp_data = 16'sh7FFF;
`else
    exp_data = -16'sd1024;
`endif
    in_valid16 = 1'b1; act16 = 8'sd127; sign16 = 1'b0; exp16 = 2'd3; mantissa16 = 1'b1;
    bsig16 = 3'd7; in_last16 = 1'b1;
    total_cnt++; if (in_ready16 !== 1'b1) $display("FAIL ovf16_ready: got %b expected 1", in_ready16); else pass_cnt++;
    tick();
    in_valid16 = 1'b0; in_last16 = 1'b0;
    tick(); tick();
    total_cnt++; if (out_valid16 !== 1'b1) $display("FAIL ovf16_valid: got %b expected 1", out_valid16); else pass_cnt++;
    total_cnt++; if (out_data16 !== exp_data) $display("FAIL ovf16_data: got %0d expected %0d", out_data16, exp_data); else pass_cnt++;
    total_cnt++; if (out_ovf16 !== 1'b1) $display("FAIL ovf16_flag: got %b expected 1", out_ovf16); else pass_cnt++;
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
    total_cnt++; if (out_ovf16 !== 1'b0) $display("FAIL ovf16_flag_clear: got %b expected 0", out_ovf16); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    put(8'sd9, 1'b0, 2'd0, 1'b1, 3'd0, 1'b1);
    tick();
    idle_in();
    tick(); tick();
    total_cnt++; if (out_data !== 24'sd9) $display("FAIL bp_data_initial: got %0d expected 9", out_data); else pass_cnt++;
    put(8'sd100, 1'b0, 2'd0, 1'b1, 3'd0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      total_cnt++; if (out_data !== 24'sd9 || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold c%0d: got data=%0d valid=%b ready=%b expected data=9 valid=1 ready=0", c, out_data, out_valid, in_ready);
      else pass_cnt++;
    end
    idle_in();
    handshake();
    total_cnt++; if (out_data !== 24'sd0) $display("FAIL bp_acc_cleared: got %0d expected 0", out_data); else pass_cnt++;
    put(8'sd1, 1'b0, 2'd0, 1'b1, 3'd0, 1'b1);
    tick();
    idle_in();
    tick(); tick();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 24'sd1)
      $display("FAIL bp_next_dot: got valid=%b data=%0d expected valid=1 data=1", out_valid, out_data);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_reset_mid();
    put(8'sd7, 1'b0, 2'd0, 1'b1, 3'd0, 1'b0);
    tick();
    put(8'sd7, 1'b0, 2'd1, 1'b1, 3'd2, 1'b0);
    tick();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total_cnt++; if (out_valid !== 1'b0 || out_data !== 24'sd0)
        $display("FAIL rst_mid_quiet c%0d: got valid=%b data=%0d expected valid=0 data=0", c, out_valid, out_data);
      else pass_cnt++;
      tick();
    end
    put(8'sd1, 1'b0, 2'd0, 1'b1, 3'd0, 1'b1);
    tick();
    idle_in();
    tick(); tick();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 24'sd1)
      $display("FAIL rst_mid_next_dot: got valid=%b data=%0d expected valid=1 data=1", out_valid, out_data);
    else pass_cnt++;
    handshake();
  endtask

  initial begin
    test_reset();
    test_two_terms();
    test_single_neg();
    test_back_to_back();
    test_overflow16();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
